hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RV32 core.
- Generates the stall/flush controls that the IF/ID and ID/EX pipeline registers and the PC consume. It is the producer side of the ID/EX `stall`/`flush` inputs.
- Detects load-use hazards, taken branches/jumps resolved in EX, and data-memory wait. A small FSM sequences multi-cycle flush and freeze windows.

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and memory-wait freeze for the 5-stage RV32 core.
// Optional statistics counters are enabled by defining HAZARD_STATS_EN.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_reg_wb,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             id_ex_hold,
   output logic             ex_mem_hold,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] freeze_count
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      FREEZE = 2'd2
   } state_e;

   localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

   state_e     state_q, state_d, eval_state;
   logic [2:0] cnt_q, cnt_d;
   logic       load_use;

   assign load_use = ex_mem_read && ex_reg_wb && (ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Leaving FREEZE is evaluated under the target state's rules in the same cycle.
   always_comb begin
      eval_state = state_q;
      if (state_q == FREEZE && !mem_busy)
         eval_state = (cnt_q != 3'd0) ? FLUSH : RUN;
   end

   always_comb begin
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_stall = 1'b0;
      id_ex_flush = 1'b0;
      id_ex_hold  = 1'b0;
      ex_mem_hold = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;

      if (reset) begin
         state_d = RUN;
         cnt_d   = '0;
      end else begin
         unique case (eval_state)
            RUN: begin
               state_d = RUN;
               if (mem_busy) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_hold  = 1'b1;
                  ex_mem_hold = 1'b1;
                  state_d     = FREEZE;
               end else if (ex_redirect) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     cnt_d   = RELOAD;
                     state_d = FLUSH;
                  end
               end else if (load_use) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_stall = 1'b1;
               end
            end
            FLUSH: begin
               if (mem_busy) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_hold  = 1'b1;
                  ex_mem_hold = 1'b1;
                  state_d     = FREEZE;
               end else begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  if (ex_redirect && RELOAD != 3'd0) begin
                     cnt_d   = RELOAD;
                     state_d = FLUSH;
                  end else if (cnt_q > 3'd1) begin
                     cnt_d   = cnt_q - 3'd1;
                     state_d = FLUSH;
                  end else begin
                     cnt_d   = '0;
                     state_d = RUN;
                  end
               end
            end
            FREEZE: begin
               pc_stall    = 1'b1;
               if_id_stall = 1'b1;
               id_ex_hold  = 1'b1;
               ex_mem_hold = 1'b1;
               state_d     = FREEZE;
            end
            default: begin
               state_d = RUN;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign state_out = reset ? 2'd0 : state_q;

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         freeze_cnt_q <= '0;
      end else begin
         if (id_ex_stall && stall_cnt_q != '1)  stall_cnt_q  <= stall_cnt_q + 1'b1;
         if (id_ex_flush && flush_cnt_q != '1)  flush_cnt_q  <= flush_cnt_q + 1'b1;
         if (ex_mem_hold && freeze_cnt_q != '1) freeze_cnt_q <= freeze_cnt_q + 1'b1;
      end
   end

   assign stall_count  = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
   assign freeze_count = freeze_cnt_q;
`else
   assign stall_count  = '0;
   assign flush_count  = '0;
   assign freeze_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (FLUSH_CYCLES=2): directed vectors queued by stimulus, checked by a negedge monitor.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_wb, ex_redirect, mem_busy;
   logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, id_ex_hold, ex_mem_hold;
   logic [1:0]  state_out;
   logic [31:0] stall_count, flush_count, freeze_count;

   always #5 clk = ~clk;

   hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_wb(ex_reg_wb),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .id_ex_hold(id_ex_hold),
      .ex_mem_hold(ex_mem_hold), .state_out(state_out),
      .stall_count(stall_count), .flush_count(flush_count), .freeze_count(freeze_count)
   );

   // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, id_ex_hold, ex_mem_hold}
   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] STL  = 7'b1101000;
   localparam logic [6:0] FLS  = 7'b0010100;
   localparam logic [6:0] FRZ  = 7'b1100011;

   typedef struct {
      string       name;
      logic [6:0]  ctrl;
      logic [1:0]  st;
      logic        chk_cnt;
      logic [31:0] sc, fc, zc;
   } exp_t;

   exp_t        q[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [31:0] t_sc = 0, t_fc = 0, t_zc = 0;

   task automatic step(input string nm, input logic rst,
                       input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic wb,
                       input logic redir, input logic busy,
                       input logic [6:0] ec, input logic [1:0] es);
      exp_t e;
      reset = rst; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
      ex_rd = rd; ex_mem_read = mr; ex_reg_wb = wb; ex_redirect = redir; mem_busy = busy;
      e.name = nm; e.ctrl = ec; e.st = es; e.chk_cnt = !rst;
`ifdef HAZARD_STATS_EN
      e.sc = t_sc; e.fc = t_fc; e.zc = t_zc;
`else
      e.sc = 0; e.fc = 0; e.zc = 0;
`endif
      q.push_back(e);
      if (rst) begin
         t_sc = 0; t_fc = 0; t_zc = 0;
      end else begin
         t_sc = t_sc + 32'(ec[3]);
         t_fc = t_fc + 32'(ec[2]);
         t_zc = t_zc + 32'(ec[0]);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: the DUT presents a response every cycle; compare it mid-cycle.
   initial begin
      exp_t  e;
      logic [6:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, id_ex_hold, ex_mem_hold};
            checks++;
            if (act !== e.ctrl) begin
               errors++;
               $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
            end
            checks++;
            if (state_out !== e.st) begin
               errors++;
               $display("FAIL %s state_out: got %0d expected %0d", e.name, state_out, e.st);
            end
            if (e.chk_cnt) begin
               checks++;
               if ({stall_count, flush_count, freeze_count} !== {e.sc, e.fc, e.zc}) begin
                  errors++;
                  $display("FAIL %s counts: got %0d/%0d/%0d expected %0d/%0d/%0d", e.name,
                           stall_count, flush_count, freeze_count, e.sc, e.fc, e.zc);
               end
            end
         end
      end
   end

   initial begin
      @(posedge clk); #1;
      step("reset0", 1, 0,0, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      step("reset1", 1, 0,0, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      step("idle",   0, 0,0, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      // load-use on rs1, then cleared
      step("lu_rs1",   0, 5,1, 0,0, 5,1,1, 0,0, STL,  2'd0);
      step("lu_clear", 0, 5,1, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      step("lu_rs2",   0, 0,0, 9,1, 9,1,1, 0,0, STL,  2'd0);
      // x0 destination and unused source never stall
      step("x0_dest",  0, 0,1, 0,0, 0,1,1, 0,0, NONE, 2'd0);
      step("unused2",  0, 0,0, 7,0, 7,1,1, 0,0, NONE, 2'd0);
      step("no_wb",    0, 3,1, 0,0, 3,1,0, 0,0, NONE, 2'd0);
      // taken branch: two flush cycles
      step("br_det",   0, 0,0, 0,0, 0,0,0, 1,0, FLS,  2'd0);
      step("br_fl2",   0, 0,0, 0,0, 0,0,0, 0,0, FLS,  2'd1);
      step("br_done",  0, 0,0, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      // redirect with load-use: flush wins, load-use ignored in FLUSH
      step("rlu_det",  0, 4,1, 0,0, 4,1,1, 1,0, FLS,  2'd0);
      step("rlu_fl2",  0, 4,1, 0,0, 4,1,1, 0,0, FLS,  2'd1);
      step("rlu_done", 0, 0,0, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      // mem_busy for 3 cycles during FLUSH (counter=1)
      step("fb_det",   0, 0,0, 0,0, 0,0,0, 1,0, FLS,  2'd0);
      step("fb_frz1",  0, 0,0, 0,0, 0,0,0, 0,1, FRZ,  2'd1);
      step("fb_frz2",  0, 0,0, 0,0, 0,0,0, 0,1, FRZ,  2'd2);
      step("fb_frz3",  0, 0,0, 0,0, 0,0,0, 0,1, FRZ,  2'd2);
      step("fb_fl",    0, 0,0, 0,0, 0,0,0, 0,0, FLS,  2'd2);
      step("fb_run",   0, 0,0, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      // mem_busy beats redirect and load-use; exit from FREEZE into a redirect
      step("pri_frz",  0, 2,1, 0,0, 2,1,1, 1,1, FRZ,  2'd0);
      step("pri_rd",   0, 0,0, 0,0, 0,0,0, 1,0, FLS,  2'd2);
      step("pri_fl2",  0, 0,0, 0,0, 0,0,0, 0,0, FLS,  2'd1);
      step("pri_lu",   0, 6,1, 0,0, 6,1,1, 0,0, STL,  2'd0);
      // reset asserted during FREEZE
      step("rf_frz1",  0, 0,0, 0,0, 0,0,0, 0,1, FRZ,  2'd0);
      step("rf_frz2",  0, 0,0, 0,0, 0,0,0, 0,1, FRZ,  2'd2);
      step("rf_rst",   1, 0,0, 0,0, 0,0,0, 0,1, NONE, 2'd0);
      step("rf_after", 0, 0,0, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      step("rf_lu",    0, 8,1, 0,0, 8,1,1, 0,0, STL,  2'd0);
      step("rf_end",   0, 0,0, 0,0, 0,0,0, 0,0, NONE, 2'd0);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
